dwt_lift_ctrl: RTL
==================

# dwt_lift_ctrl

Parametrised control unit for the multi-level 5/3 lifting DWT datapath. It owns its own sample and level counters, so no external count is needed. It performs the even/odd split and generates the even-buffer enables and the detail/coarse valids, aligned to the predict/update pipeline latency. Coarse coefficients are written back and re-fed for up to LEVELS decomposition levels per block, and `block_done` pulses when the block is finished.

## Interface
- BLOCK_LEN, 8: samples per block at level 0; power of two, ≥4.
- LEVELS, 3: decomposition levels; 1 ≤ LEVELS ≤ $clog2(BLOCK_LEN)−1.
- PIPE_LAT, 2: predict-stage latency (cycles) from odd-sample accept to detail result; ≥1.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  level-0 input sample valid; only accepted while ready_out=1.
- internal_valid  in  1  re-fed coarse sample valid from coarse buffer; honoured only in FEED.
- ready_out  out  1  controller accepts valid_in (IDLE/LOAD).
- iseven  out  1  current sample index is even (index 0 even).
- even_wr_en  out  1  write accepted even sample into even buffer.
- even_rd_en  out  1  read stored even sample (same cycle as odd accept).
- coarse_rd_en  out  1  request next coarse sample for re-feed.
- valid_detailOut  out  1  detail coefficient valid.
- valid_coarseOut  out  1  coarse coefficient valid.
- coarse_coeff_wr_en  out  1  write coarse coefficient back for next level.
- level  out  $clog2(LEVELS+1)  current level (0-based).
- busy  out  1  state ≠ IDLE.
- block_done  out  1  one-cycle pulse at block completion.

## Operation
- States: IDLE, LOAD, DRAIN, FEED, DONE. The reset state is IDLE, and every output resets to 0 except ready_out, which resets to 1. All counters and delay lines also clear.
- IDLE: ready_out=1. The first accepted valid_in moves the FSM to LOAD and counts as sample 0.
- A sample is accepted when valid_in&&ready_out (level 0) or internal_valid&&state==FEED (level >0).
- Level length: len = BLOCK_LEN>>level. The sample index idx counts 0..len−1, and iseven = ~idx[0].
- Even accept: even_wr_en=1.
- Odd accept: even_rd_en=1 in the same cycle, and a token enters the valid delay line.
- The accept that makes idx==len−1 ends the level: LOAD or FEED → DRAIN next cycle, and idx wraps to 0.
- LOAD: ready_out=1. valid_in gaps are allowed; nothing advances without an accept.
- DRAIN: ready_out=0 for exactly PIPE_LAT+1 cycles.
  - If level+1 < LEVELS: go to FEED with level+1.
  - Otherwise: go to DONE.
- FEED: coarse_rd_en=1 for exactly len consecutive cycles from FEED entry. Samples are counted on internal_valid.
- DONE: block_done=1 for one cycle, then IDLE with level=0.
- coarse_coeff_wr_en = valid_coarseOut && (level of producing pair < LEVELS−1). The final level's coarse output is not written back.
- valid_in while ready_out=0 is ignored. internal_valid outside FEED is ignored.
- Per block: Σ len/2 detail pulses and the same number of coarse pulses.
  - Example, BLOCK_LEN=8, LEVELS=3: 7 detail, 7 coarse, 6 writebacks.
- A reset assertion at any point aborts the block immediately and returns the FSM to reset values. No partial outputs appear after reset.

## Timing
- Odd accept at cycle T:
  - valid_detailOut at T+PIPE_LAT.
  - valid_coarseOut (and coarse_coeff_wr_en, if applicable) at T+PIPE_LAT+1.
- Delay-line tokens carry their level tag, so valids from level k are never suppressed by the transition to level k+1.
- Last odd accept at T:
  - DRAIN occupies T+1..T+PIPE_LAT+1.
  - FEED or DONE starts at T+PIPE_LAT+2, after the last coarse write.
- Continuous input: one sample per cycle, with no bubbles inside LOAD.
- The next block can start in the cycle after DONE.

## Structure
- Package dwt_pkg holds:
  - the state enum typedef (dwt_state_t);
  - a function lvl_len(level) returning BLOCK_LEN>>level;
  - the token struct {valid, level}.
- Sub-module dwt_valid_delay(DEPTH, W): a resettable shift register carrying the odd-accept token. It provides taps at PIPE_LAT (detail) and PIPE_LAT+1 (coarse).

## Test plan
- Reset, then 8 back-to-back valid_in from cycle 0 (8/3/2):
  - even_wr_en at cycles 0,2,4,6; even_rd_en at 1,3,5,7.
  - detail at 3,5,7,9; coarse with writeback at 4,6,8,10.
  - FEED at cycle 11 with level=1.
- Full block, internal_valid returned 1 cycle after each coarse_rd_en:
  - Totals of 7 detail, 7 coarse and 6 coarse_coeff_wr_en.
  - The level-2 coarse has coarse_coeff_wr_en=0.
  - block_done is exactly one pulse, followed by IDLE.
- valid_in with gaps (high every other cycle): outputs match the continuous case shifted by the gaps; valid_in while ready_out=0 produces no effect.
- internal_valid pulsed during LOAD or DRAIN: no counter or output change.
- Reset asserted mid-FEED at level 1: next cycle all outputs 0, ready_out=1, level=0; no stray valids afterwards.
- Param sweep BLOCK_LEN=16, LEVELS=1, PIPE_LAT=1:
  - 8 detail, 8 coarse, 0 writebacks.
  - DONE follows 2 DRAIN cycles after the 16th sample.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared types for the 5/3 lifting DWT controller: FSM states, delay-line token,
// and the per-level length helper.
package dwt_pkg;

    localparam int unsigned TOK_LVL_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StFeed,
        StDone
    } dwt_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TOK_LVL_W-1:0] level;
    } dwt_token_t;

    function automatic int unsigned lvl_len(input int unsigned block_len,
                                            input int unsigned level);
        return block_len >> level;
    endfunction

endpackage

// File: rtl/dwt_valid_delay.sv
// Resettable shift register carrying odd-accept tokens; taps line up with the
// predict (detail) and update (coarse) pipeline stages.
module dwt_valid_delay #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] tap_detail,
    output logic [W-1:0] tap_coarse
);

    logic [DEPTH-1:0][W-1:0] sr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[DEPTH-2:0], din};
        end
    end

    // Stage k is visible k+1 cycles after the accept that loaded it.
    assign tap_detail = sr_q[DEPTH-2];
    assign tap_coarse = sr_q[DEPTH-1];

endmodule

// File: rtl/dwt_lift_ctrl.sv
// Control unit for the multi-level 5/3 lifting DWT: even/odd split, level
// sequencing with coarse re-feed, and pipeline-aligned detail/coarse valids.
module dwt_lift_ctrl
    import dwt_pkg::*;
#(
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned LEVELS    = 3,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic                         internal_valid,
    output logic                         ready_out,
    output logic                         iseven,
    output logic                         even_wr_en,
    output logic                         even_rd_en,
    output logic                         coarse_rd_en,
    output logic                         valid_detailOut,
    output logic                         valid_coarseOut,
    output logic                         coarse_coeff_wr_en,
    output logic [$clog2(LEVELS+1)-1:0]  level,
    output logic                         busy,
    output logic                         block_done
);

    localparam int unsigned IDX_W = $clog2(BLOCK_LEN);
    localparam int unsigned LVL_W = $clog2(LEVELS + 1);
    localparam int unsigned DRN_W = $clog2(PIPE_LAT + 2);

    dwt_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [DRN_W-1:0] drain_q, drain_d;
    logic [IDX_W:0]   feed_q, feed_d;
    logic             accept;
    logic             last_sample;
    int unsigned      len;
    dwt_token_t       tok_in, tok_det, tok_crs;
    logic             unused_det_lvl;

    assign len         = lvl_len(BLOCK_LEN, 32'(level_q));
    assign last_sample = (32'(idx_q) == len - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            level_q <= '0;
            drain_q <= '0;
            feed_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            drain_q <= drain_d;
            feed_q  <= feed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        level_d      = level_q;
        drain_d      = drain_q;
        feed_d       = feed_q;
        ready_out    = 1'b0;
        coarse_rd_en = 1'b0;
        block_done   = 1'b0;
        accept       = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_out = 1'b1;
                accept    = valid_in;
                if (valid_in) state_d = StLoad;
            end
            StLoad: begin
                ready_out = 1'b1;
                accept    = valid_in;
            end
            StDrain: begin
                drain_d = drain_q + 1'b1;
                if (32'(drain_q) == PIPE_LAT) begin
                    drain_d = '0;
                    if (32'(level_q) + 1 < LEVELS) begin
                        level_d = level_q + 1'b1;
                        feed_d  = '0;
                        state_d = StFeed;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFeed: begin
                accept       = internal_valid;
                coarse_rd_en = (32'(feed_q) < len);
                if (coarse_rd_en) feed_d = feed_q + 1'b1;
            end
            StDone: begin
                block_done = 1'b1;
                level_d    = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            if (last_sample) begin
                idx_d   = '0;
                drain_d = '0;
                state_d = StDrain;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign even_wr_en = accept & ~idx_q[0];
    assign even_rd_en = accept & idx_q[0];
    assign iseven     = ~idx_q[0] & (accept | (state_q == StLoad) | (state_q == StFeed));
    assign busy       = (state_q != StIdle);
    assign level      = level_q;

    // Tokens keep the producing level so late valids survive the level change.
    assign tok_in = {even_rd_en, TOK_LVL_W'(level_q)};

    dwt_valid_delay #(
        .DEPTH (PIPE_LAT + 1),
        .W     ($bits(dwt_token_t))
    ) u_valid_delay (
        .clk        (clk),
        .reset      (reset),
        .din        (tok_in),
        .tap_detail (tok_det),
        .tap_coarse (tok_crs)
    );

    assign valid_detailOut    = tok_det.valid;
    assign valid_coarseOut    = tok_crs.valid;
    assign coarse_coeff_wr_en = tok_crs.valid && (32'(tok_crs.level) + 1 < LEVELS);
    assign unused_det_lvl     = ^tok_det.level;

endmodule
